// File: rtl/collision_pkg.sv
// Shared types and default geometry for the collision scanner.
// Widths and ground row are defaults; the scanner parameters may override them.
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_e;

    localparam int DEF_X_W      = 11;
    localparam int DEF_Y_W      = 9;
    localparam int DEF_W_W      = 8;
    localparam int DEF_H_W      = 7;
    localparam int DEF_GROUND_Y = 200;

endpackage

// File: rtl/collision_box_cmp.sv
// Combinational overlap test of the dino box against one obstacle slot.
// Obstacles sit on the ground row; the hitbox shrinks by MARGIN on each side.
module collision_box_cmp
    import collision_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int W_W      = DEF_W_W,
    parameter int H_W      = DEF_H_W,
    parameter int GROUND_Y = DEF_GROUND_Y,
    parameter int MARGIN   = 2
) (
    input  logic           active,
    input  logic [X_W-1:0] dino_x,
    input  logic [Y_W-1:0] dino_y,
    input  logic [W_W-1:0] dino_w,
    input  logic [X_W-1:0] obs_x,
    input  logic [W_W-1:0] obs_w,
    input  logic [H_W-1:0] obs_h,
    output logic           hit
);

    localparam int XE = X_W + 2;
    localparam int YE = Y_W + 1;

    // Widened sums so no edge comparison can wrap.
    logic [XE-1:0] dino_r;
    logic [XE-1:0] dino_l;
    logic [XE-1:0] obs_l;
    logic [XE-1:0] obs_r;
    logic [YE-1:0] obs_top_reach;
    logic          horiz;
    logic          vert;

    assign dino_r        = XE'(dino_x) + XE'(dino_w);
    assign dino_l        = XE'(dino_x) + XE'(2 * MARGIN);
    assign obs_l         = XE'(obs_x) + XE'(2 * MARGIN);
    assign obs_r         = XE'(obs_x) + XE'(obs_w);
    assign obs_top_reach = YE'(dino_y) + YE'(obs_h);

    assign horiz = (dino_r > obs_l) && (dino_l < obs_r);
    assign vert  = (obs_top_reach >= YE'(GROUND_Y + MARGIN));

    assign hit = active && (obs_w != '0) && (obs_h != '0) && horiz && vert;

endmodule

// File: rtl/collision_scanner.sv
// Per-frame serial collision scan: snapshots dino and obstacle boxes on a
// frame tick, tests one slot per clock, and latches a debounced game-over.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for an accepted frame_tick
// ST_SCAN   | testing snapshot slot idx, one per clock
// ST_COMMIT | publish frame results, update hit counter / collided
module collision_scanner
    import collision_pkg::*;
#(
    parameter int NUM_OBS    = 4,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int W_W        = DEF_W_W,
    parameter int H_W        = DEF_H_W,
    parameter int GROUND_Y   = DEF_GROUND_Y,
    parameter int MARGIN     = 2,
    parameter int HIT_FRAMES = 2,
    localparam int IDX_W     = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   frame_tick,
    input  logic [X_W-1:0]         dino_x,
    input  logic [Y_W-1:0]         dino_y,
    input  logic [W_W-1:0]         dino_w,
    input  logic [NUM_OBS*X_W-1:0] obs_x,
    input  logic [NUM_OBS*W_W-1:0] obs_w,
    input  logic [NUM_OBS*H_W-1:0] obs_h,
    input  logic [NUM_OBS-1:0]     obs_active,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   hit_now,
    output logic [IDX_W-1:0]       hit_idx,
    output logic                   collided,
    output logic                   overrun
);

    localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES + 1) : 1;

    scan_state_e state_q, state_d;

    logic [IDX_W-1:0]       idx_q;
    logic                   any_hit_q;
    logic [IDX_W-1:0]       first_idx_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_new;

    logic [X_W-1:0]         snap_dino_x;
    logic [Y_W-1:0]         snap_dino_y;
    logic [W_W-1:0]         snap_dino_w;
    logic [NUM_OBS*X_W-1:0] snap_obs_x;
    logic [NUM_OBS*W_W-1:0] snap_obs_w;
    logic [NUM_OBS*H_W-1:0] snap_obs_h;
    logic [NUM_OBS-1:0]     snap_active;

    logic [X_W-1:0] slot_x  [NUM_OBS];
    logic [W_W-1:0] slot_w  [NUM_OBS];
    logic [H_W-1:0] slot_h  [NUM_OBS];

    logic tick_ok;
    logic accept;
    logic overrun_d;
    logic last_slot;
    logic slot_hit;

    always_comb begin
        for (int i = 0; i < NUM_OBS; i++) begin
            slot_x[i] = snap_obs_x[i*X_W +: X_W];
            slot_w[i] = snap_obs_w[i*W_W +: W_W];
            slot_h[i] = snap_obs_h[i*H_W +: H_W];
        end
    end

    collision_box_cmp #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .W_W      (W_W),
        .H_W      (H_W),
        .GROUND_Y (GROUND_Y),
        .MARGIN   (MARGIN)
    ) u_cmp (
        .active (snap_active[idx_q]),
        .dino_x (snap_dino_x),
        .dino_y (snap_dino_y),
        .dino_w (snap_dino_w),
        .obs_x  (slot_x[idx_q]),
        .obs_w  (slot_w[idx_q]),
        .obs_h  (slot_h[idx_q]),
        .hit    (slot_hit)
    );

    assign busy      = (state_q != ST_IDLE);
    assign last_slot = (idx_q == IDX_W'(NUM_OBS - 1));

    // Counter saturates at HIT_FRAMES; a miss frame restarts the run.
    always_comb begin
        cnt_new = '0;
        if (any_hit_q) begin
            cnt_new = (cnt_q == CNT_W'(HIT_FRAMES)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_ok   = frame_tick && enable && !clear;
        accept    = 1'b0;
        overrun_d = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_ok) begin
                        accept  = 1'b1;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    overrun_d = tick_ok;
                    if (last_slot) state_d = ST_COMMIT;
                end
                ST_COMMIT: begin
                    overrun_d = tick_ok;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            any_hit_q   <= 1'b0;
            first_idx_q <= '0;
            cnt_q       <= '0;
            snap_dino_x <= '0;
            snap_dino_y <= '0;
            snap_dino_w <= '0;
            snap_obs_x  <= '0;
            snap_obs_w  <= '0;
            snap_obs_h  <= '0;
            snap_active <= '0;
            frame_done  <= 1'b0;
            hit_now     <= 1'b0;
            hit_idx     <= '0;
            collided    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= 1'b0;
            overrun    <= overrun_d;
            if (clear) begin
                idx_q       <= '0;
                any_hit_q   <= 1'b0;
                first_idx_q <= '0;
                cnt_q       <= '0;
                hit_now     <= 1'b0;
                hit_idx     <= '0;
                collided    <= 1'b0;
            end else begin
                if (accept) begin
                    snap_dino_x <= dino_x;
                    snap_dino_y <= dino_y;
                    snap_dino_w <= dino_w;
                    snap_obs_x  <= obs_x;
                    snap_obs_w  <= obs_w;
                    snap_obs_h  <= obs_h;
                    snap_active <= obs_active;
                    idx_q       <= '0;
                    any_hit_q   <= 1'b0;
                    first_idx_q <= '0;
                end
                if (state_q == ST_SCAN) begin
                    if (slot_hit && !any_hit_q) first_idx_q <= idx_q;
                    any_hit_q <= any_hit_q | slot_hit;
                    if (!last_slot) idx_q <= idx_q + 1'b1;
                end
                if (state_q == ST_COMMIT) begin
                    hit_now    <= any_hit_q;
                    hit_idx    <= any_hit_q ? first_idx_q : '0;
                    frame_done <= 1'b1;
                    cnt_q      <= cnt_new;
                    if (cnt_new == CNT_W'(HIT_FRAMES)) collided <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed self-checking bench for collision_scanner at NUM_OBS=4,
// GROUND_Y=200, MARGIN=2, HIT_FRAMES=2.
module tb_collision_scanner;

    localparam int NUM_OBS = 4;
    localparam int X_W = 11;
    localparam int Y_W = 9;
    localparam int W_W = 8;
    localparam int H_W = 7;
    localparam int IDX_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic                   clear = 1'b0;
    logic                   frame_tick = 1'b0;
    logic [X_W-1:0]         dino_x = '0;
    logic [Y_W-1:0]         dino_y = '0;
    logic [W_W-1:0]         dino_w = '0;
    logic [NUM_OBS*X_W-1:0] obs_x = '0;
    logic [NUM_OBS*W_W-1:0] obs_w = '0;
    logic [NUM_OBS*H_W-1:0] obs_h = '0;
    logic [NUM_OBS-1:0]     obs_active = '0;
    logic                   busy;
    logic                   frame_done;
    logic                   hit_now;
    logic [IDX_W-1:0]       hit_idx;
    logic                   collided;
    logic                   overrun;

    int total = 0;
    int fails = 0;
    int lat;
    int n_ov;
    int n_fd;

    always #5 clk = ~clk;

    collision_scanner #(
        .NUM_OBS(NUM_OBS), .X_W(X_W), .Y_W(Y_W), .W_W(W_W), .H_W(H_W),
        .GROUND_Y(200), .MARGIN(2), .HIT_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .frame_tick(frame_tick), .dino_x(dino_x), .dino_y(dino_y),
        .dino_w(dino_w), .obs_x(obs_x), .obs_w(obs_w), .obs_h(obs_h),
        .obs_active(obs_active), .busy(busy), .frame_done(frame_done),
        .hit_now(hit_now), .hit_idx(hit_idx), .collided(collided),
        .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input int x, input int w, input int h, input logic act);
        obs_x[i*X_W +: X_W] = X_W'(x);
        obs_w[i*W_W +: W_W] = W_W'(w);
        obs_h[i*H_W +: H_W] = H_W'(h);
        obs_active[i]       = act;
    endtask

    // Called one time unit after a rising edge; returns edges from tick to frame_done.
    task automatic run_frame(output int edges);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        edges = 0;
        while (!frame_done && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    initial begin
        dino_x = 50; dino_y = 200; dino_w = 40;
        for (int i = 0; i < NUM_OBS; i++) set_slot(i, 500, 20, 30, 1'b0);
        set_slot(2, 80, 20, 30, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_hit_now", hit_now, 0);
        chk("rst_hit_idx", hit_idx, 0);
        chk("rst_collided", collided, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        enable = 1'b1;
        @(posedge clk); #1;

        // 1: single overlapping slot 2
        run_frame(lat);
        chk("t1_latency", lat, 5);
        chk("t1_hit_now", hit_now, 1);
        chk("t1_hit_idx", hit_idx, 2);
        chk("t1_collided", collided, 0);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", frame_done, 0);
        chk("t1_busy_idle", busy, 0);
        run_frame(lat);
        chk("t1_collided2", collided, 1);
        pulse_clear();
        chk("clr_collided", collided, 0);
        chk("clr_hit_now", hit_now, 0);

        // 2: a miss frame breaks the consecutive run
        run_frame(lat);
        chk("t2_hit_a", hit_now, 1);
        dino_y = 165;
        run_frame(lat);
        chk("t2_miss", hit_now, 0);
        chk("t2_miss_collided", collided, 0);
        dino_y = 200;
        run_frame(lat);
        chk("t2_hit_b", hit_now, 1);
        chk("t2_collided", collided, 0);

        // 3: horizontal margin edge on slot 0
        set_slot(2, 500, 20, 30, 1'b0);
        set_slot(0, 86, 20, 30, 1'b1);
        run_frame(lat);
        chk("t3_x86", hit_now, 0);
        set_slot(0, 85, 20, 30, 1'b1);
        run_frame(lat);
        chk("t3_x85", hit_now, 1);
        chk("t3_idx", hit_idx, 0);

        // 4: lowest active overlapping slot wins
        set_slot(0, 80, 20, 30, 1'b0);
        set_slot(1, 80, 20, 30, 1'b1);
        set_slot(2, 500, 20, 30, 1'b0);
        set_slot(3, 75, 20, 30, 1'b1);
        run_frame(lat);
        chk("t4_hit_now", hit_now, 1);
        chk("t4_hit_idx", hit_idx, 1);
        chk("t4_collided", collided, 1);

        // enable low: tick ignored with no overrun
        enable = 1'b0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        chk("en0_busy", busy, 0);
        chk("en0_overrun", overrun, 0);
        enable = 1'b1;

        // 5: ticks during SCAN and COMMIT
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        n_ov = 0;
        n_fd = 0;
        for (int e = 1; e <= 8; e++) begin
            frame_tick = (e == 2 || e == 5);
            @(posedge clk); #1;
            frame_tick = 1'b0;
            n_ov += int'(overrun);
            n_fd += int'(frame_done);
        end
        chk("t5_overruns", n_ov, 2);
        chk("t5_frame_done", n_fd, 1);

        // clear during a scan
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pulse_clear();
        chk("clrmid_busy", busy, 0);
        chk("clrmid_collided", collided, 0);
        n_fd = 0;
        for (int e = 0; e < 6; e++) begin
            n_fd += int'(frame_done);
            @(posedge clk); #1;
        end
        chk("clrmid_no_done", n_fd, 0);

        // 6: async reset mid-scan after collided is set
        run_frame(lat);
        run_frame(lat);
        chk("t6_pre_collided", collided, 1);
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_hit_now", hit_now, 0);
        chk("t6_rst_hit_idx", hit_idx, 0);
        chk("t6_rst_collided", collided, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(lat);
        chk("t6_latency", lat, 5);
        chk("t6_hit_idx", hit_idx, 1);
        chk("t6_collided", collided, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
